// File: rtl/pid_controller_param.sv
// pid_controller_param: parametrised PID controller with programmable
// fixed-point gains, a saturating integrator, a valid/ready sample handshake
// and an output saturation flag. One sample is processed every five cycles
// through IDLE -> ERR -> TERMS -> SUM -> OUT.
// Optional feature macro: PID_DERIV_EN. When it is defined, the derivative
// path and the prev_error register are built. When it is undefined, the
// d term is zero and Kd is writable but has no effect.
module pid_controller_param #(
  parameter int DATA_W  = 8,
  parameter int GAIN_W  = 8,
  parameter int FRAC_W  = 4,
  parameter int ACC_W   = 16,
  parameter int KP_INIT = 32,
  parameter int KI_INIT = 0,
  parameter int KD_INIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] setpoint,
  input  logic [DATA_W-1:0] feedback,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [GAIN_W-1:0] cfg_data,
  output logic [DATA_W-1:0] control_out,
  output logic              out_valid,
  output logic              sat
);

  // Error, derivative and integrator-sum widths.
  localparam int E_W   = DATA_W + 1;
  localparam int D_W   = DATA_W + 2;
  localparam int IS_W  = ((ACC_W > E_W) ? ACC_W : E_W) + 1;
  // Widest signed operand of a gain product. The extra bits leave headroom
  // for the gain sign bit and for the sum of three products.
  localparam int OP_W  = (ACC_W > D_W) ? ACC_W : D_W;
  localparam int SUM_W = GAIN_W + 1 + OP_W + 2;

  localparam logic signed [IS_W-1:0]  I_MAX = (IS_W'(1) <<< (ACC_W - 1)) - IS_W'(1);
  localparam logic signed [IS_W-1:0]  I_MIN = -I_MAX;
  localparam logic signed [SUM_W-1:0] U_MAX = (SUM_W'(1) <<< DATA_W) - SUM_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERR   = 3'd1,
    S_TERMS = 3'd2,
    S_SUM   = 3'd3,
    S_OUT   = 3'd4
  } state_e;

  state_e state_q;

  // Programmable gains, written through the configuration port.
  logic [GAIN_W-1:0] kp_q, ki_q, kd_q;
  // Working copies captured at accept.
  logic [GAIN_W-1:0] kp_w_q, ki_w_q, kd_w_q;
  logic [DATA_W-1:0] sp_w_q, fb_w_q;

  logic signed [E_W-1:0]   e_q, e_d;
  logic signed [ACC_W-1:0] integ_q, integ_d;
  logic signed [D_W-1:0]   d_q;
  logic signed [IS_W-1:0]  integ_sum;
  logic signed [SUM_W-1:0] acc_d, u_full;
  logic [DATA_W-1:0]       u_q, u_d;
  logic                    clamp_q, clamp_d;

  logic [DATA_W-1:0]       control_out_q;
  logic                    out_valid_q, sat_q;

  logic clear_integ;
  assign clear_integ = cfg_we && (cfg_addr == 2'd3);

`ifdef PID_DERIV_EN
  logic signed [E_W-1:0] prev_q;
  logic signed [D_W-1:0] d_d;
`else
  assign d_q = '0;
`endif

  // Datapath arithmetic for the ERR, TERMS and SUM steps.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
    e_d       = $signed({1'b0, sp_w_q}) - $signed({1'b0, fb_w_q});

    integ_sum = IS_W'(integ_q) + IS_W'(e_q);
    if (integ_sum > I_MAX) begin
      integ_d = ACC_W'(I_MAX);
    end else if (integ_sum < I_MIN) begin
      integ_d = ACC_W'(I_MIN);
    end else begin
      integ_d = ACC_W'(integ_sum);
    end

`ifdef PID_DERIV_EN
    d_d = D_W'(e_q) - D_W'(prev_q);
`endif

    acc_d  = SUM_W'($signed({1'b0, kp_w_q})) * SUM_W'(e_q)
           + SUM_W'($signed({1'b0, ki_w_q})) * SUM_W'(integ_q)
           + SUM_W'($signed({1'b0, kd_w_q})) * SUM_W'(d_q);
    u_full = acc_d >>> FRAC_W;

    u_d     = u_full[DATA_W-1:0];
    clamp_d = 1'b0;
    if (u_full < 0) begin
      u_d     = '0;
      clamp_d = 1'b1;
    end else if (u_full > U_MAX) begin
      u_d     = '1;
      clamp_d = 1'b1;
    end
  end

  // Gain registers: a write lands at the clock edge. A working copy captured
  // at the same edge still sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kp_q <= GAIN_W'(KP_INIT);
      ki_q <= GAIN_W'(KI_INIT);
      kd_q <= GAIN_W'(KD_INIT);
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0:    kp_q <= cfg_data;
        2'd1:    ki_q <= cfg_data;
        2'd2:    kd_q <= cfg_data;
        default: ;
      endcase
    end
  end

  // Sequencer and pipeline state: one sample walks the five states.
  // Outputs are registered in OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      kp_w_q        <= '0;
      ki_w_q        <= '0;
      kd_w_q        <= '0;
      sp_w_q        <= '0;
      fb_w_q        <= '0;
      e_q           <= '0;
      integ_q       <= '0;
      u_q           <= '0;
      clamp_q       <= 1'b0;
      control_out_q <= '0;
      out_valid_q   <= 1'b0;
      sat_q         <= 1'b0;
`ifdef PID_DERIV_EN
      d_q           <= '0;
      prev_q        <= '0;
`endif
    end else begin
      // NOTE: state uses non-blocking assignments, so every right-hand side reads the pre-edge value.
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sp_w_q  <= setpoint;
            fb_w_q  <= feedback;
            kp_w_q  <= kp_q;
            ki_w_q  <= ki_q;
            kd_w_q  <= kd_q;
            state_q <= S_ERR;
          end
        end
        S_ERR: begin
          e_q     <= e_d;
          state_q <= S_TERMS;
        end
        S_TERMS: begin
          integ_q <= integ_d;
`ifdef PID_DERIV_EN
          d_q     <= d_d;
`endif
          state_q <= S_SUM;
        end
        S_SUM: begin
          u_q     <= u_d;
          clamp_q <= clamp_d;
          state_q <= S_OUT;
        end
        S_OUT: begin
          control_out_q <= u_q;
          sat_q         <= clamp_q;
          out_valid_q   <= 1'b1;
`ifdef PID_DERIV_EN
          prev_q        <= e_q;
`endif
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // NOTE: this is the last assignment to integ_q in the block, so a clear in the TERMS cycle overrides the update.
      if (clear_integ) begin
        integ_q <= '0;
      end
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign control_out = control_out_q;
  assign out_valid   = out_valid_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_pid_controller_param.sv
// Bench for pid_controller_param. Randomized and directed samples are
// compared against a plain-integer PID model.
module tb_pid_controller_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] setpoint, feedback;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [7:0] control_out;
  logic       out_valid;
  logic       sat;

  int n_total = 0;
  int n_bad   = 0;

`ifdef PID_DERIV_EN
  localparam bit DERIV = 1'b1;
`else
  localparam bit DERIV = 1'b0;
`endif
  localparam longint I_LIM = 32767;

  // Reference model state.
  longint m_kp, m_ki, m_kd, m_integ, m_prev;

  pid_controller_param dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .setpoint    (setpoint),
    .feedback    (feedback),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .control_out (control_out),
    .out_valid   (out_valid),
    .sat         (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div16(input longint a);
    if (a >= 0) return a / 16;
    return -((-a + 15) / 16);
  endfunction

  task automatic model_reset();
    m_kp = 32; m_ki = 0; m_kd = 0; m_integ = 0; m_prev = 0;
  endtask

  // Write one configuration register. Called at posedge+1.
  task automatic cfg_write(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = 2'(addr); cfg_data = 8'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    case (addr)
      0: m_kp = data;
      1: m_ki = data;
      2: m_kd = data;
      default: m_integ = 0;
    endcase
  endtask

  // One sample.
  // mode 0: plain.
  // mode 1: config write in the accept cycle.
  // mode 2: integrator clear at the TERMS edge.
  // mode 3: in_valid held high with changing data while busy.
  task automatic run_sample(input int sp, input int fb, input int mode,
                            input int caddr, input int cdata, input string tag);
    longint e, d, acc, u, exp_u;
    int     exp_sat, guard;
    bit     early;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    setpoint = 8'(sp); feedback = 8'(fb); in_valid = 1'b1;
    if (mode == 1) begin
      cfg_we = 1'b1; cfg_addr = 2'(caddr); cfg_data = 8'(cdata);
    end

    // Model: the old gains apply to this sample, and a clear at accept precedes the integration.
    if (mode == 1 && caddr == 3) m_integ = 0;
    e = longint'(sp) - longint'(fb);
    m_integ = m_integ + e;
    if (m_integ > I_LIM)  m_integ = I_LIM;
    if (m_integ < -I_LIM) m_integ = -I_LIM;
    if (mode == 2) m_integ = 0;
    d   = DERIV ? (e - m_prev) : 0;
    acc = m_kp * e + m_ki * m_integ + m_kd * d;
    u   = floor_div16(acc);
    exp_sat = 0;
    exp_u   = u;
    if (u < 0)   begin exp_u = 0;   exp_sat = 1; end
    if (u > 255) begin exp_u = 255; exp_sat = 1; end
    m_prev = e;
    if (mode == 1) begin
      case (caddr)
        0: m_kp = cdata;
        1: m_ki = cdata;
        2: m_kd = cdata;
        default: ;
      endcase
    end

    @(posedge clk); #1;  // accept edge k
    if (mode != 3) in_valid = 1'b0;
    cfg_we = 1'b0;
    early = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (mode == 2 && i == 1) begin cfg_we = 1'b1; cfg_addr = 2'd3; end
      if (mode == 2 && i == 2) cfg_we = 1'b0;
      if (mode == 3 && i == 1) begin setpoint = 8'($urandom_range(0, 255)); feedback = 8'($urandom_range(0, 255)); end
      if (mode == 3 && i == 3) in_valid = 1'b0;
      if (i < 4 && out_valid === 1'b1) early = 1'b1;
    end
    check({tag, "_early"}, 64'(early), 64'd0);
    check({tag, "_ovalid"}, 64'(out_valid), 64'd1);
    check({tag, "_out"}, 64'(control_out), 64'(exp_u));
    check({tag, "_sat"}, 64'(sat), 64'(exp_sat));
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(out_valid), 64'd0);
    check({tag, "_hold"}, 64'(control_out), 64'(exp_u));
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; setpoint = '0; feedback = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 64'(control_out), 64'd0);
    check("rst_ovalid", 64'(out_valid), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // Proportional term with the default Kp of 2.0.
    run_sample(100, 60, 0, 0, 0, "prop");

    // Reset in the middle of a computation.
    setpoint = 8'd200; feedback = 8'd10; in_valid = 1'b1;
    @(posedge clk); #1;  // accept edge k
    in_valid = 1'b0;
    @(posedge clk); #1;  // edge k+1
    rst = 1'b1;
    @(posedge clk); #1;  // edge k+2
    rst = 1'b0;
    model_reset();
    check("midrst_out", 64'(control_out), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("midrst_noov", 64'(seen), 64'd0);
    run_sample(100, 60, 0, 0, 0, "after_rst");

    // Output clamping.
    run_sample(200, 0, 0, 0, 0, "clamp_hi");
    run_sample(0, 50, 0, 0, 0, "clamp_lo");

    // Integral term, then an integrator clear.
    cfg_write(0, 0);
    cfg_write(1, 16);
    cfg_write(3, 0);
    run_sample(10, 0, 0, 0, 0, "int1");
    run_sample(10, 0, 0, 0, 0, "int2");
    run_sample(10, 0, 0, 0, 0, "int3");
    cfg_write(3, 0);
    run_sample(10, 0, 0, 0, 0, "int_clr");
    run_sample(10, 0, 2, 0, 0, "clr_terms");
    run_sample(10, 0, 0, 0, 0, "after_clr");

    // Derivative term.
    cfg_write(1, 0);
    cfg_write(2, 16);
    run_sample(50, 50, 0, 0, 0, "der0");
    run_sample(70, 50, 0, 0, 0, "der1");
    run_sample(70, 50, 0, 0, 0, "der2");

    // A gain write in the accept cycle must not affect the current sample.
    cfg_write(2, 0);
    cfg_write(0, 16);
    run_sample(40, 0, 1, 0, 64, "same_cyc");
    run_sample(40, 0, 0, 0, 0, "new_gain");
    run_sample(30, 0, 3, 0, 0, "busy_ign");

    // Integrator windup in both directions.
    cfg_write(0, 0);
    cfg_write(1, 1);
    cfg_write(3, 0);
    for (int i = 0; i < 140; i++) run_sample(255, 0, 0, 0, 0, "wind_pos");
    for (int i = 0; i < 260; i++) run_sample(0, 255, 0, 0, 0, "wind_neg");
    cfg_write(3, 0);

    // Random samples, gains and side conditions.
    for (int n = 0; n < 80; n++) begin
      int mode;
      if ($urandom_range(0, 3) == 0) cfg_write($urandom_range(0, 3), $urandom_range(0, 40));
      mode = $urandom_range(0, 3);
      run_sample($urandom_range(0, 255), $urandom_range(0, 255), mode,
                 $urandom_range(0, 3), $urandom_range(0, 40), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
